// File: rtl/prog_mem.sv
// Serially programmed instruction store: a bit-serial loader fills a flop array
// word by word while load_en_i is high; the execution stage reads it combinationally.
module prog_mem #(
  parameter int INSTR_WIDTH = 7,
  parameter int PC_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en_i,
  input  logic                   cfg_valid_i,
  input  logic                   cfg_bit_i,
  output logic                   cfg_ready_o,
  input  logic [PC_WIDTH-1:0]    pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    wr_addr_o,
  output logic                   done_o
);

  localparam int DEPTH = 2 ** PC_WIDTH;
  localparam int CNT_W = $clog2(INSTR_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] word_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [PC_WIDTH-1:0]    wr_addr_q;
  logic                   accept;
  logic                   last_bit;

  assign accept   = cfg_ready_o & cfg_valid_i;
  assign last_bit = accept && (bit_cnt_q == CNT_W'(INSTR_WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch;
  // the default also sends the unused encoding back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = load_en_i ? SHIFT : IDLE;
      SHIFT: begin
        if (!load_en_i)    state_d = IDLE;
        else if (last_bit) state_d = COMMIT;
        else               state_d = SHIFT;
      end
      COMMIT:  state_d = load_en_i ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      SHIFT:   cfg_ready_o = load_en_i;
      COMMIT:  done_o      = &wr_addr_q;
      default: ;
    endcase
  end

  // Word assembly and write pointer; a fresh load always restarts at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      bit_cnt_q <= '0;
      wr_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_en_i) begin
            bit_cnt_q <= '0;
            wr_addr_q <= '0;
          end
        end
        SHIFT: begin
          if (!load_en_i) begin
            bit_cnt_q <= '0;
          end else if (accept) begin
            word_q    <= {word_q[INSTR_WIDTH-2:0], cfg_bit_i};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        COMMIT: begin
          bit_cnt_q <= '0;
          wr_addr_q <= wr_addr_q + PC_WIDTH'(1);
        end
        default: bit_cnt_q <= '0;
      endcase
    end
  end

  // NOTE: the array is built from flops, so it can be cleared by reset; a
  // reset in the COMMIT cycle takes priority and suppresses the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == COMMIT) begin
      mem_q[wr_addr_q] <= word_q;
    end
  end

  assign instr_o   = load_en_i ? '0 : mem_q[pc_i];
  assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: serial loading, read-back, wrap, abort and
// reset-during-commit scenarios, each compared against hand-derived values.
module tb_prog_mem;

  localparam int IW = 7;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en_i;
  logic          cfg_valid_i;
  logic          cfg_bit_i;
  logic          cfg_ready_o;
  logic [PW-1:0] pc_i;
  logic [IW-1:0] instr_o;
  logic [PW-1:0] wr_addr_o;
  logic          done_o;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] words [16] = '{7'h01, 7'h7e, 7'h2a, 7'h55, 7'h13, 7'h64, 7'h0f, 7'h70,
                                7'h3c, 7'h43, 7'h66, 7'h19, 7'h5a, 7'h25, 7'h7f, 7'h4d};
  logic [IW-1:0] w17 [17];
  logic [IW-1:0] partial_word;

  always #5 clk = ~clk;

  prog_mem #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en_i   (load_en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_bit_i   (cfg_bit_i),
    .cfg_ready_o (cfg_ready_o),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .wr_addr_o   (wr_addr_o),
    .done_o      (done_o)
  );

  // Advance to a new cycle; inputs are driven 2 ns after the rising edge.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered in a SHIFT cycle; returns in the COMMIT cycle with cfg_valid_i still high.
  task automatic send_word(input logic [IW-1:0] w, input bit gapped, input string tag);
    int g;
    for (int b = IW - 1; b >= 0; b--) begin
      if (gapped) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          cfg_valid_i = 1'b0;
          cfg_bit_i   = 1'($urandom_range(0, 1));
          next();
        end
      end
      cfg_valid_i = 1'b1;
      cfg_bit_i   = w[b];
      #1;
      check({tag, " ready"}, 32'(cfg_ready_o), 32'd1);
      next();
    end
  endtask

  task automatic read_check(input string tag, input logic [PW-1:0] addr, input logic [IW-1:0] exp);
    pc_i = addr;
    #1;
    check(tag, 32'(instr_o), 32'(exp));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) w17[k] = words[k] ^ 7'h7f;
    w17[16] = 7'h31;

    rst = 1'b1; load_en_i = 1'b0; cfg_valid_i = 1'b0; cfg_bit_i = 1'b0; pc_i = '0;
    next();
    next();
    #1;
    check("rst ready", 32'(cfg_ready_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst wr_addr", 32'(wr_addr_o), 32'd0);

    // Cleared memory reads zero everywhere.
    rst = 1'b0;
    next();
    for (int a = 0; a < 16; a++) read_check($sformatf("sweep %0d", a), PW'(a), '0);

    // Single word 1010011 into address 0.
    load_en_i = 1'b1; cfg_valid_i = 1'b1; cfg_bit_i = 1'b1;
    #1;
    check("idle ready", 32'(cfg_ready_o), 32'd0);
    check("load instr zero", 32'(instr_o), 32'd0);
    next();
    send_word(7'b1010011, 1'b0, "w0");
    #1;
    check("w0 commit ready", 32'(cfg_ready_o), 32'd0);
    check("w0 commit done", 32'(done_o), 32'd0);
    check("w0 commit addr", 32'(wr_addr_o), 32'd0);
    load_en_i = 1'b0;
    next();
    #1;
    check("w0 wr_addr", 32'(wr_addr_o), 32'd1);
    read_check("w0 readback", 4'd0, 7'b1010011);

    // Full pass of 16 gapped words; done only on the last commit.
    cfg_valid_i = 1'b0; load_en_i = 1'b1;
    next();
    for (int k = 0; k < 16; k++) begin
      send_word(words[k], 1'b1, $sformatf("p16 w%0d", k));
      #1;
      check($sformatf("p16 done %0d", k), 32'(done_o), (k == 15) ? 32'd1 : 32'd0);
      check($sformatf("p16 addr %0d", k), 32'(wr_addr_o), 32'(k));
      next();
    end
    cfg_valid_i = 1'b0;
    #1;
    check("p16 wrap addr", 32'(wr_addr_o), 32'd0);
    check("p16 done after", 32'(done_o), 32'd0);
    load_en_i = 1'b0;
    next();
    for (int a = 0; a < 16; a++) read_check($sformatf("p16 rd %0d", a), PW'(a), words[a]);

    // 17 words: the last one wraps onto address 0, done still fires once.
    load_en_i = 1'b1;
    next();
    for (int k = 0; k < 17; k++) begin
      send_word(w17[k], 1'b0, $sformatf("p17 w%0d", k));
      #1;
      check($sformatf("p17 done %0d", k), 32'(done_o), (k == 15) ? 32'd1 : 32'd0);
      next();
    end
    cfg_valid_i = 1'b0; load_en_i = 1'b0;
    next();
    read_check("p17 rd 0", 4'd0, w17[16]);
    read_check("p17 rd 1", 4'd1, w17[1]);
    read_check("p17 rd 15", 4'd15, w17[15]);

    // Abort after 4 bits of the word at address 2.
    load_en_i = 1'b1;
    next();
    send_word(7'h11, 1'b0, "ab w0");
    next();
    send_word(7'h22, 1'b0, "ab w1");
    next();
    partial_word = 7'h6b;
    for (int b = IW - 1; b >= IW - 4; b--) begin
      cfg_valid_i = 1'b1;
      cfg_bit_i   = partial_word[b];
      next();
    end
    load_en_i = 1'b0;
    #1;
    check("ab drop ready", 32'(cfg_ready_o), 32'd0);
    next();
    #1;
    check("ab idle addr", 32'(wr_addr_o), 32'd2);
    read_check("ab rd 2", 4'd2, w17[2]);
    read_check("ab rd 1", 4'd1, 7'h22);
    load_en_i = 1'b1;
    #1;
    check("ab idle ready", 32'(cfg_ready_o), 32'd0);
    next();
    #1;
    check("ab reload addr", 32'(wr_addr_o), 32'd0);
    send_word(7'h3e, 1'b0, "ab reload");
    #1;
    check("ab reload commit ready", 32'(cfg_ready_o), 32'd0);
    check("ab reload commit addr", 32'(wr_addr_o), 32'd0);
    load_en_i = 1'b0;
    next();
    read_check("ab rd 0", 4'd0, 7'h3e);

    // Reset during COMMIT wins over the write.
    load_en_i = 1'b1;
    next();
    send_word(7'h5d, 1'b0, "rc");
    rst = 1'b1; load_en_i = 1'b0; cfg_valid_i = 1'b0;
    next();
    rst = 1'b0;
    #1;
    check("rc ready", 32'(cfg_ready_o), 32'd0);
    check("rc done", 32'(done_o), 32'd0);
    check("rc wr_addr", 32'(wr_addr_o), 32'd0);
    read_check("rc rd 0", 4'd0, '0);
    read_check("rc rd 1", 4'd1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter INSTR_WIDTH, default 7, width of one instruction word.
REQ-002 Parameter PC_WIDTH, default 4, address width; depth = 2**PC_WIDTH words (16 by default).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_en_i  input  1  programming window; high = loading, low = run.
REQ-006 cfg_valid_i  input  1  serial bit offered this cycle.
REQ-007 cfg_bit_i  input  1  serial data bit, MSB of each word first.
REQ-008 cfg_ready_o  output  1  block accepts a bit this cycle.
REQ-009 pc_i  input  PC_WIDTH  read address from the execution stage.
REQ-010 instr_o  output  INSTR_WIDTH  instruction at pc_i.
REQ-011 wr_addr_o  output  PC_WIDTH  address the next completed word is written to.
REQ-012 done_o  output  1  one-cycle pulse when the word at address 2**PC_WIDTH-1 is written.

Function
REQ-013 Storage SHALL be a flop array of 2**PC_WIDTH x INSTR_WIDTH.
REQ-014 instr_o SHALL be a combinational read of mem[pc_i] while load_en_i is low, with no added latency.
REQ-015 instr_o SHALL be all-zero while load_en_i is high.
REQ-016 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-017 IDLE: cfg_ready_o=0; on load_en_i=1 -> SHIFT, with bit count and wr_addr cleared.
REQ-018 SHIFT: cfg_ready_o = load_en_i.
REQ-019 SHIFT: a bit is accepted when cfg_valid_i and cfg_ready_o are both high; accepted bits shift into the LSB of the word register, and the bit count increments.
REQ-020 SHIFT: the INSTR_WIDTH-th accepted bit of a word -> COMMIT.
REQ-021 COMMIT (exactly one cycle):
- cfg_ready_o=0; cfg_valid_i is ignored.
- mem[wr_addr] is written with the assembled word.
- wr_addr increments modulo 2**PC_WIDTH (15 -> 0 wraps silently).
- bit count clears.
- done_o=1 if wr_addr was all-ones.
- next state: SHIFT if load_en_i=1, else IDLE.
REQ-022 The word write SHALL land one cycle after the last bit is accepted; it is visible on instr_o once load_en_i is low.
REQ-023 load_en_i falling in SHIFT SHALL discard any partial word, return to IDLE, and leave memory untouched.
REQ-024 load_en_i falling in COMMIT SHALL still complete the write, then go to IDLE.
REQ-025 A new rising edge of load_en_i SHALL restart writing at address 0; earlier contents persist until overwritten.
REQ-026 done_o SHALL be high for exactly one cycle per completed full pass and low at all other times.
REQ-027 Any illegal FSM encoding SHALL go to IDLE.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL be cleared:
- FSM -> IDLE.
- all memory words -> 0.
- word register, bit count and wr_addr -> 0.
- cfg_ready_o=0, done_o=0.
REQ-029 Reset SHALL override an in-progress load, including a COMMIT cycle: no write occurs.

Verification
REQ-030 Reset, then load_en_i=0 and sweep pc_i 0..15 -> instr_o=0 at every address.
REQ-031 load_en_i=1, stream word 7'b1010011 with cfg_valid_i held high, drop load_en_i -> mem[0]=7'b1010011, wr_addr_o=1, cfg_ready_o low during the COMMIT cycle, pc_i=0 -> instr_o=7'b1010011.
REQ-032 Stream 16 words with cfg_valid_i gapped randomly -> done_o pulses once, on the 16th COMMIT; wr_addr_o=0 afterwards; all 16 words read back correctly.
REQ-033 Stream 17 words -> word 17 overwrites address 0; done_o pulses only once.
REQ-034 Drop load_en_i after 4 bits of word 2 -> address 2 unchanged, FSM in IDLE; a reload starts at address 0 with bit count 0.
REQ-035 Assert rst in the COMMIT cycle -> target address remains 0; all outputs at reset values the next cycle.
